// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register.
// Frames are start bit, 8 data bits and a stop bit, each bit held for
// 2*HALF_BIT_TICS clk50 cycles. A byte waiting in the holding register
// follows the previous stop bit with no idle gap. txd, busy and ready
// are all driven straight from flops.
module uart_tx #(
   parameter int HALF_BIT_TICS = 217,
   parameter bit MSB_FIRST     = 1'b1
) (
   input  logic     clk50,
   input  logic     rst_n,
   uart_tx_if.slave bus,
   output logic     txd,
   output logic     busy
);

   // Last tick of a bit period; the legal HALF_BIT_TICS range keeps it in 10 bits.
   localparam logic [9:0] BIT_LAST = 10'(2 * HALF_BIT_TICS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0] state_r;
   logic [7:0] hold_r;
   logic       hold_full_r;
   logic [7:0] shift_r;
   logic [9:0] cnt_r;
   logic [2:0] idx_r;
   logic       txd_r;
   logic       busy_r;
   logic       ready_r;

   logic [1:0] state_s;
   logic [7:0] hold_s;
   logic       hold_full_s;
   logic [7:0] shift_s;
   logic [9:0] cnt_s;
   logic [2:0] idx_s;
   logic       txd_s;
   logic       busy_s;
   logic       ready_s;
   logic       accept_s;
   logic       cnt_end_s;
   logic       direct_s;
   logic       capture_s;

   // Data bit that goes on the line at bit index i, honouring the bit order.
   function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i);
      logic bit_v;
      if (MSB_FIRST) begin
         bit_v = b[3'd7 - i];
      end else begin
         bit_v = b[i];
      end
      return bit_v;
   endfunction

   assign accept_s  = bus.valid && !hold_full_r;
   assign cnt_end_s = (cnt_r == BIT_LAST);

   // Next-state logic: frame sequencing, direct loads and holding-register capture.
   always_comb begin
      state_s     = state_r;
      hold_s      = hold_r;
      hold_full_s = hold_full_r;
      shift_s     = shift_r;
      cnt_s       = cnt_r;
      idx_s       = idx_r;
      txd_s       = txd_r;
      direct_s    = 1'b0;
      capture_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            cnt_s = 10'd0;
            idx_s = 3'd0;
            if (accept_s) begin
               // Line is free: skip the holding register and start at once.
               direct_s = 1'b1;
               shift_s  = bus.data;
               state_s  = ST_START;
               txd_s    = 1'b0;
            end else begin
               state_s = ST_IDLE;
               txd_s   = 1'b1;
            end
         end

         ST_START: begin
            if (cnt_end_s) begin
               cnt_s   = 10'd0;
               idx_s   = 3'd0;
               state_s = ST_DATA;
               txd_s   = pick_bit(shift_r, 3'd0);
            end else begin
               cnt_s = cnt_r + 10'd1;
               txd_s = 1'b0;
            end
         end

         ST_DATA: begin
            if (cnt_end_s) begin
               cnt_s = 10'd0;
               if (idx_r == 3'd7) begin
                  idx_s   = 3'd0;
                  state_s = ST_STOP;
                  txd_s   = 1'b1;
               end else begin
                  idx_s = idx_r + 3'd1;
                  txd_s = pick_bit(shift_r, idx_r + 3'd1);
               end
            end else begin
               cnt_s = cnt_r + 10'd1;
               txd_s = pick_bit(shift_r, idx_r);
            end
         end

         ST_STOP: begin
            if (cnt_end_s) begin
               cnt_s = 10'd0;
               idx_s = 3'd0;
               if (hold_full_r) begin
                  // Queued byte follows the stop bit with no idle cycle.
                  shift_s     = hold_r;
                  hold_full_s = 1'b0;
                  state_s     = ST_START;
                  txd_s       = 1'b0;
               end else if (accept_s) begin
                  // Handshake on the final stop edge behaves like a load from idle.
                  direct_s = 1'b1;
                  shift_s  = bus.data;
                  state_s  = ST_START;
                  txd_s    = 1'b0;
               end else begin
                  state_s = ST_IDLE;
                  txd_s   = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + 10'd1;
               txd_s = 1'b1;
            end
         end

         default: begin
            state_s = ST_IDLE;
            cnt_s   = 10'd0;
            idx_s   = 3'd0;
            txd_s   = 1'b1;
         end
      endcase

      // Any accepted byte that did not start a frame directly waits in hold.
      capture_s = accept_s && !direct_s;
      if (capture_s) begin
         hold_s      = bus.data;
         hold_full_s = 1'b1;
      end else begin
         hold_s = hold_r;
      end

      busy_s  = (state_s != ST_IDLE) || hold_full_s;
      ready_s = !hold_full_s;
   end

   // State and output registers; reset aborts any frame and drops the held byte.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         hold_r      <= 8'h00;
         hold_full_r <= 1'b0;
         shift_r     <= 8'h00;
         cnt_r       <= 10'd0;
         idx_r       <= 3'd0;
         txd_r       <= 1'b1;
         busy_r      <= 1'b0;
         ready_r     <= 1'b1;
      end else begin
         state_r     <= state_s;
         hold_r      <= hold_s;
         hold_full_r <= hold_full_s;
         shift_r     <= shift_s;
         cnt_r       <= cnt_s;
         idx_r       <= idx_s;
         txd_r       <= txd_s;
         busy_r      <= busy_s;
         ready_r     <= ready_s;
      end
   end

   assign txd       = txd_r;
   assign busy      = busy_r;
   assign bus.ready = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two short-bit instances (MSB and LSB first)
// for timing-exact frame checks, and a default-rate instance looped back
// into a bench-side MSB-first receiver.
module tb_uart_tx;

   localparam int HALF_D = 217;
   localparam int BT_D   = 434;

   logic clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   logic rst_a, rst_b, rst_c;
   logic txd_a, txd_b, txd_c;
   logic busy_a, busy_b, busy_c;

   uart_tx_if bus_a ();
   uart_tx_if bus_b ();
   uart_tx_if bus_c ();

   uart_tx #(.HALF_BIT_TICS(4), .MSB_FIRST(1'b1)) dut_a (
      .clk50(clk50), .rst_n(rst_a), .bus(bus_a), .txd(txd_a), .busy(busy_a));
   uart_tx #(.HALF_BIT_TICS(4), .MSB_FIRST(1'b0)) dut_b (
      .clk50(clk50), .rst_n(rst_b), .bus(bus_b), .txd(txd_b), .busy(busy_b));
   uart_tx #(.HALF_BIT_TICS(HALF_D), .MSB_FIRST(1'b1)) dut_c (
      .clk50(clk50), .rst_n(rst_c), .bus(bus_c), .txd(txd_c), .busy(busy_c));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Free-running cycle counter, stable when read at the falling edge.
   always @(posedge clk50) cyc <= cyc + 1;

   logic log_a [0:4095];
   logic log_b [0:4095];

   // Per-cycle txd record of the short-bit instances.
   always @(negedge clk50) begin
      if (cyc < 4096) begin
         log_a[cyc] <= txd_a;
         log_b[cyc] <= txd_b;
      end
   end

   logic [7:0] rx_q [$];
   logic       rx_stop_q [$];

   // Receiver model: mid-bit sampling, MSB first.
   always begin : rx_model
      logic [7:0] b;
      logic       st;
      @(negedge txd_c);
      repeat (HALF_D) @(negedge clk50);
      if (txd_c === 1'b0) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) begin
            repeat (BT_D) @(negedge clk50);
            b = {b[6:0], txd_c};
         end
         repeat (BT_D) @(negedge clk50);
         st = txd_c;
         rx_q.push_back(b);
         rx_stop_q.push_back(st);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      case (sel)
         0: begin bus_a.valid = v; bus_a.data = d; end
         1: begin bus_b.valid = v; bus_b.data = d; end
         default: begin bus_c.valid = v; bus_c.data = d; end
      endcase
   endtask

   // Hand a byte over, waiting for ready; returns one cycle after acceptance.
   task automatic send_c(input logic [7:0] b, input string tag);
      int n;
      n = 0;
      drive(2, 1'b1, b);
      while (bus_c.ready !== 1'b1 && n < 10000) begin
         @(negedge clk50);
         n++;
      end
      chk({tag, "_accept_in_time"}, 32'(n < 10000), 32'd1);
      @(negedge clk50);
   endtask

   // Compare 10 recorded bit periods (8 cycles each) against the expected frame.
   task automatic check_frame(input int sel, input int s, input logic [7:0] b,
                              input logic msb, input string tag);
      logic [7:0] seen;
      logic [7:0] expv;
      logic       e;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      e = 1'b0;
         else if (k == 9) e = 1'b1;
         else if (msb)    e = b[8 - k];
         else             e = b[k - 1];
         for (int c = 0; c < 8; c++) begin
            seen[c] = (sel == 0) ? log_a[s + k * 8 + c] : log_b[s + k * 8 + c];
            expv[c] = e;
         end
         chk($sformatf("%s_bit%0d", tag, k), {24'd0, seen}, {24'd0, expv});
      end
   endtask

   int s, r, n, zeros;
   logic [7:0] tog;
   logic [7:0] lb_bytes [4];

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      #5;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      repeat (3) @(negedge clk50);
      chk("rst_txd_a", txd_a, 32'd1);
      chk("rst_ready_a", bus_a.ready, 32'd1);
      chk("rst_busy_a", busy_a, 32'd0);
      chk("rst_txd_c", txd_c, 32'd1);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (5) @(negedge clk50);
      chk("idle_after_release_txd", txd_a, 32'd1);
      chk("idle_after_release_busy", busy_a, 32'd0);

      // 1: single byte 0xA5, MSB first, 8-cycle bits
      drive(0, 1'b1, 8'hA5);
      @(negedge clk50);
      s = cyc;
      drive(0, 1'b0, 8'h00);
      chk("t1_start_low", txd_a, 32'd0);
      chk("t1_ready_direct", bus_a.ready, 32'd1);
      chk("t1_busy", busy_a, 32'd1);
      n = 0;
      while (busy_a === 1'b1 && n < 200) begin @(negedge clk50); n++; end
      chk("t1_frame_len", 32'(cyc - s), 32'd80);
      @(negedge clk50);
      chk("t1_idle_before", log_a[s - 1], 32'd1);
      check_frame(0, s, 8'hA5, 1'b1, "t1");
      chk("t1_idle_after", log_a[s + 80], 32'd1);

      // 2: LSB first, 0x01
      drive(1, 1'b1, 8'h01);
      @(negedge clk50);
      s = cyc;
      drive(1, 1'b0, 8'h00);
      n = 0;
      while (busy_b === 1'b1 && n < 200) begin @(negedge clk50); n++; end
      chk("t2_frame_len", 32'(cyc - s), 32'd80);
      @(negedge clk50);
      check_frame(1, s, 8'h01, 1'b0, "t2");

      // 3: back-to-back 0x3C, 0xC3, 0xFF with valid held high
      drive(0, 1'b1, 8'h3C);
      @(negedge clk50);
      s = cyc;
      chk("t3_ready_after_direct", bus_a.ready, 32'd1);
      drive(0, 1'b1, 8'hC3);
      @(negedge clk50);
      chk("t3_ready_hold_full", bus_a.ready, 32'd0);
      chk("t3_busy_hold_full", busy_a, 32'd1);
      drive(0, 1'b1, 8'hFF);
      n = 0;
      while (bus_a.ready !== 1'b1 && n < 200) begin @(negedge clk50); n++; end
      chk("t3_ready_return", 32'(cyc - s), 32'd80);
      @(negedge clk50);
      chk("t3_third_held", bus_a.ready, 32'd0);
      drive(0, 1'b0, 8'h00);
      n = 0;
      while (busy_a === 1'b1 && n < 400) begin @(negedge clk50); n++; end
      chk("t3_total_len", 32'(cyc - s), 32'd240);
      @(negedge clk50);
      check_frame(0, s, 8'h3C, 1'b1, "t3_f1");
      check_frame(0, s + 80, 8'hC3, 1'b1, "t3_f2");
      check_frame(0, s + 160, 8'hFF, 1'b1, "t3_f3");
      chk("t3_idle_after", log_a[s + 240], 32'd1);

      // 4: data toggles every cycle while hold is full
      drive(0, 1'b1, 8'h11);
      @(negedge clk50);
      s = cyc;
      drive(0, 1'b1, 8'h22);
      @(negedge clk50);
      tog = 8'h96;
      n = 0;
      while (bus_a.ready !== 1'b1 && n < 200) begin
         drive(0, 1'b1, tog);
         tog = ~tog;
         @(negedge clk50);
         n++;
      end
      chk("t4_ready_return", 32'(cyc - s), 32'd80);
      drive(0, 1'b1, 8'hE7);
      @(negedge clk50);
      drive(0, 1'b0, 8'h00);
      n = 0;
      while (busy_a === 1'b1 && n < 400) begin @(negedge clk50); n++; end
      @(negedge clk50);
      check_frame(0, s, 8'h11, 1'b1, "t4_f1");
      check_frame(0, s + 80, 8'h22, 1'b1, "t4_f2");
      check_frame(0, s + 160, 8'hE7, 1'b1, "t4_f3");

      // 5: reset during data bit 3 of 0x55 with 0x0F held
      drive(0, 1'b1, 8'h55);
      @(negedge clk50);
      s = cyc;
      drive(0, 1'b1, 8'h0F);
      @(negedge clk50);
      drive(0, 1'b0, 8'h00);
      repeat (34) @(negedge clk50);
      chk("t5_pre_ready", bus_a.ready, 32'd0);
      chk("t5_pre_busy", busy_a, 32'd1);
      #3 rst_a = 1'b0;
      #1;
      chk("t5_async_txd", txd_a, 32'd1);
      chk("t5_async_ready", bus_a.ready, 32'd1);
      chk("t5_async_busy", busy_a, 32'd0);
      drive(0, 1'b1, 8'hAA);
      repeat (2) @(negedge clk50);
      drive(0, 1'b0, 8'h00);
      @(negedge clk50);
      rst_a = 1'b1;
      r = cyc;
      repeat (100) @(negedge clk50);
      zeros = 0;
      for (int i = 0; i < 99; i++) if (log_a[r + i] !== 1'b1) zeros++;
      chk("t5_idle_after_release", zeros, 32'd0);
      chk("t5_busy_after_release", busy_a, 32'd0);
      drive(0, 1'b1, 8'h81);
      @(negedge clk50);
      s = cyc;
      drive(0, 1'b0, 8'h00);
      n = 0;
      while (busy_a === 1'b1 && n < 200) begin @(negedge clk50); n++; end
      @(negedge clk50);
      check_frame(0, s, 8'h81, 1'b1, "t5_after");

      // 5b: reset while txd is low in a start bit
      drive(1, 1'b1, 8'h00);
      @(negedge clk50);
      drive(1, 1'b0, 8'h00);
      repeat (3) @(negedge clk50);
      chk("t5b_start_low", txd_b, 32'd0);
      #3 rst_b = 1'b0;
      #1;
      chk("t5b_async_txd", txd_b, 32'd1);
      repeat (2) @(negedge clk50);
      rst_b = 1'b1;
      repeat (20) @(negedge clk50);
      chk("t5b_idle_txd", txd_b, 32'd1);
      chk("t5b_idle_busy", busy_b, 32'd0);

      // 6: loopback at the default bit rate
      lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A; lb_bytes[3] = 8'h81;
      for (int i = 0; i < 4; i++) send_c(lb_bytes[i], $sformatf("t6_send%0d", i));
      drive(2, 1'b0, 8'h00);
      n = 0;
      while (rx_q.size() < 4 && n < 30000) begin @(negedge clk50); n++; end
      chk("t6_rx_count", rx_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < rx_q.size()) begin
            chk($sformatf("t6_rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, lb_bytes[i]});
            chk($sformatf("t6_rx_stop%0d", i), rx_stop_q[i], 32'd1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
